// File: rtl/pcie_msi_vec_ctrl.sv
// Multi-vector PCIe MSI generator: capability registers, per-vector pending latch, round-robin grant.
// Optional feature macro: MSI_PER_VECTOR_MASK_EN enables the MASK and PENDING registers.
module pcie_msi_vec_ctrl #(
    parameter int NUM_VECTORS = 32,
    parameter int ADDR_W      = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             cfg_addr,
    input  logic [31:0]            cfg_wdata,
    input  logic                   cfg_write,
    output logic [31:0]            cfg_rdata,
    input  logic [NUM_VECTORS-1:0] irq_req,
    output logic                   msi_valid,
    input  logic                   msi_ready,
    output logic [ADDR_W-1:0]      msi_addr,
    output logic [15:0]            msi_data,
    output logic [4:0]             msi_vector,
    output logic                   msi_enabled
);
    localparam int         IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [2:0] MMC   = 3'($clog2(NUM_VECTORS));

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t                 state_q, state_d;
    logic                   en_q, en_d;
    logic [2:0]             mme_q, mme_d;
    logic [29:0]            addr_lo_q, addr_lo_d;
    logic [31:0]            addr_hi_q, addr_hi_d;
    logic [15:0]            data_q, data_d;
    logic [NUM_VECTORS-1:0] mask_q, mask_d;
    logic [NUM_VECTORS-1:0] pend_q, pend_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [4:0]             vec_q, vec_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [15:0]            mdata_q, mdata_d;

    logic [7:0]             word_addr;
    logic [5:0]             lim;
    logic [15:0]            vec_mask;
    logic [NUM_VECTORS-1:0] req_fold, elig, pend_clr;
    logic                   found;
    logic [IDX_W-1:0]       pick, idx, cur_idx;
    logic [63:0]            full_addr;

    assign word_addr = cfg_addr & 8'hFC;
    assign lim       = 6'd1 << mme_q;
    assign vec_mask  = (16'd1 << mme_q) - 16'd1;
    assign full_addr = {addr_hi_q, addr_lo_q, 2'b00};
    assign cur_idx   = vec_q[IDX_W-1:0];

    always_comb begin
        cfg_rdata = '0;
        case (word_addr)
            8'h00:   cfg_rdata = {25'd0, mme_q, MMC, en_q};
            8'h04:   cfg_rdata = {addr_lo_q, 2'b00};
            8'h08:   cfg_rdata = (ADDR_W == 64) ? addr_hi_q : 32'd0;
            8'h0C:   cfg_rdata = {16'd0, data_q};
`ifdef MSI_PER_VECTOR_MASK_EN
            8'h10:   cfg_rdata = 32'(mask_q);
            8'h14:   cfg_rdata = 32'(pend_q);
`endif
            default: cfg_rdata = '0;
        endcase
    end

    always_comb begin
        en_d      = en_q;
        mme_d     = mme_q;
        addr_lo_d = addr_lo_q;
        addr_hi_d = addr_hi_q;
        data_d    = data_q;
        mask_d    = mask_q;
        if (cfg_write) begin
            case (word_addr)
                8'h00: begin
                    en_d  = cfg_wdata[0];
                    mme_d = (cfg_wdata[6:4] > MMC) ? MMC : cfg_wdata[6:4];
                end
                8'h04: addr_lo_d = cfg_wdata[31:2];
                8'h08: if (ADDR_W == 64) addr_hi_d = cfg_wdata;
                8'h0C: data_d = cfg_wdata[15:0];
`ifdef MSI_PER_VECTOR_MASK_EN
                8'h10: mask_d = cfg_wdata[NUM_VECTORS-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Requests above the enabled vector count collapse onto the highest enabled vector.
    always_comb begin
        req_fold = '0;
        elig     = '0;
        for (int v = 0; v < NUM_VECTORS; v++) begin
            if (irq_req[v]) begin
                if (v < int'(lim)) req_fold[v] = 1'b1;
                else               req_fold[IDX_W'(lim - 6'd1)] = 1'b1;
            end
            elig[v] = pend_q[v] & ~mask_q[v] & en_q & (v < int'(lim));
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            idx = ptr_q + IDX_W'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        vec_d    = vec_q;
        addr_d   = addr_q;
        mdata_d  = mdata_q;
        pend_clr = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_REQ;
                    vec_d   = 5'(pick);
                    addr_d  = full_addr[ADDR_W-1:0];
                    mdata_d = (data_q & ~vec_mask) | (16'(pick) & vec_mask);
                end
            end
            S_REQ: begin
                if (msi_ready) begin
                    pend_clr[cur_idx] = 1'b1;
                    ptr_d   = (NUM_VECTORS == 1) ? '0 : cur_idx + IDX_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Set after clear so an event arriving on the handshake cycle is kept.
        pend_d = (pend_q & ~pend_clr) | req_fold;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            mme_q     <= '0;
            addr_lo_q <= '0;
            addr_hi_q <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            pend_q    <= '0;
            ptr_q     <= '0;
            vec_q     <= '0;
            addr_q    <= '0;
            mdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mme_q     <= mme_d;
            addr_lo_q <= addr_lo_d;
            addr_hi_q <= addr_hi_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            vec_q     <= vec_d;
            addr_q    <= addr_d;
            mdata_q   <= mdata_d;
        end
    end

    assign msi_valid   = (state_q == S_REQ);
    assign msi_addr    = addr_q;
    assign msi_data    = mdata_q;
    assign msi_vector  = vec_q;
    assign msi_enabled = en_q;

endmodule

// File: tb/tb_pcie_msi_vec_ctrl.sv
// Self-checking bench for pcie_msi_vec_ctrl: event-level reference model plus directed scenarios.
module tb_pcie_msi_vec_ctrl;
   localparam int NV = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic        cfg_write = 1'b0;
   logic [31:0] cfg_rdata;
   logic [NV-1:0] irq_req = '0;
   logic        msi_valid;
   logic        msi_ready = 1'b1;
   logic [63:0] msi_addr;
   logic [15:0] msi_data;
   logic [4:0]  msi_vector;
   logic        msi_enabled;

   int checks = 0;
   int errors = 0;

   logic [4:0]  logVec[$];
   logic [15:0] logData[$];

   // Reference model state: the capability registers, the set of pending events and the in-flight MSI.
   logic [31:0] mPend, mMask, mLo, mHi, mNext;
   logic        mEn, mBusy, mFound;
   int          mMme, mPtr, mVec, mLim, mV;
   logic [15:0] mData, mOData;
   logic [63:0] mOAddr;

   pcie_msi_vec_ctrl #(.NUM_VECTORS(NV), .ADDR_W(64)) dut (
      .clk(clk), .rst(rst),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_write(cfg_write), .cfg_rdata(cfg_rdata),
      .irq_req(irq_req),
      .msi_valid(msi_valid), .msi_ready(msi_ready),
      .msi_addr(msi_addr), .msi_data(msi_data), .msi_vector(msi_vector),
      .msi_enabled(msi_enabled)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic nextCycle();
      @(negedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] wdata);
      cfg_addr  = addr;
      cfg_wdata = wdata;
      cfg_write = 1'b1;
      nextCycle();
      cfg_write = 1'b0;
   endtask

   task automatic pulseIrq(input logic [NV-1:0] vecs);
      irq_req = vecs;
      nextCycle();
      irq_req = '0;
   endtask

   task automatic readReg(input string name, input logic [7:0] addr, input logic [31:0] expected);
      cfg_addr = addr;
      nextCycle();
      checkOutput(name, {32'd0, cfg_rdata}, {32'd0, expected});
   endtask

   task automatic checkLog(input string name, input int idx, input int vec, input int data);
      checks++;
      if (logVec.size() <= idx) begin
         errors++;
         $display("[TB] FAIL %s: only %0d MSIs seen, required entry %0d", name, logVec.size(), idx);
      end else if (logVec[idx] !== 5'(vec) || logData[idx] !== 16'(data)) begin
         errors++;
         $display("[TB] FAIL %s: got vector %0d data 0x%0h, expected vector %0d data 0x%0h",
                  name, logVec[idx], logData[idx], vec, data);
      end
   endtask

   // Record every accepted MSI in order.
   always @(posedge clk) begin
      if (!rst && msi_valid && msi_ready) begin
         logVec.push_back(msi_vector);
         logData.push_back(msi_data);
      end
   end

   // Model: an idle generator picks the first servable event at/after the round-robin pointer;
   // a busy one waits for acceptance; new events join the pending set afterwards.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mPend = '0; mMask = '0; mLo = '0; mHi = '0; mEn = 1'b0; mMme = 0;
         mData = '0; mPtr = 0; mBusy = 1'b0; mVec = 0; mOAddr = '0; mOData = '0;
      end else begin
         mLim  = 1 << mMme;
         mNext = mPend;
         if (mBusy) begin
            if (msi_ready) begin
               mNext[mVec] = 1'b0;
               mPtr  = (mVec + 1) % NV;
               mBusy = 1'b0;
            end
         end else begin
            mFound = 1'b0;
            for (int i = 0; i < NV; i++) begin
               mV = (mPtr + i) % NV;
               if (!mFound && mEn && mPend[mV] && !mMask[mV] && mV < mLim) begin
                  mFound = 1'b1;
                  mBusy  = 1'b1;
                  mVec   = mV;
                  mOAddr = {mHi, mLo};
                  mOData = (mData & ~16'(mLim - 1)) | 16'(mV);
               end
            end
         end
         for (int v = 0; v < NV; v++)
            if (irq_req[v]) mNext[(v < mLim) ? v : mLim - 1] = 1'b1;
         mPend = mNext;
         if (cfg_write) begin
            case (cfg_addr & 8'hFC)
               8'h00: begin
                  mEn  = cfg_wdata[0];
                  mMme = (int'(cfg_wdata[6:4]) > 5) ? 5 : int'(cfg_wdata[6:4]);
               end
               8'h04: mLo = cfg_wdata & 32'hFFFF_FFFC;
               8'h08: mHi = cfg_wdata;
               8'h0C: mData = cfg_wdata[15:0];
`ifdef MSI_PER_VECTOR_MASK_EN
               8'h10: mMask = cfg_wdata;
`endif
               default: ;
            endcase
         end
      end
   end

   // Every cycle out of reset the DUT must match the model.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("model_valid", {63'd0, msi_valid}, {63'd0, mBusy});
         checkOutput("model_enabled", {63'd0, msi_enabled}, {63'd0, mEn});
         if (mBusy) begin
            checkOutput("model_addr", msi_addr, mOAddr);
            checkOutput("model_data", {48'd0, msi_data}, {48'd0, mOData});
            checkOutput("model_vector", {59'd0, msi_vector}, 64'(mVec));
         end
      end
   end

   initial begin
      #1 rst = 1'b1;
      repeat (3) nextCycle();
      rst = 1'b0;
      nextCycle();

      $display("[TB] reset state");
      checkOutput("rst_valid", {63'd0, msi_valid}, 64'd0);
      checkOutput("rst_addr", msi_addr, 64'd0);
      checkOutput("rst_data", {48'd0, msi_data}, 64'd0);
      checkOutput("rst_vector", {59'd0, msi_vector}, 64'd0);
      checkOutput("rst_enabled", {63'd0, msi_enabled}, 64'd0);
      readReg("rst_ctrl", 8'h00, 32'h0000_000A);

      $display("[TB] register access");
      applyStimulus(8'h04, 32'hFEE0_0003);
      readReg("addr_lo_ro_bits", 8'h04, 32'hFEE0_0000);
      applyStimulus(8'h08, 32'h0000_0012);
      readReg("addr_hi", 8'h08, 32'h0000_0012);
      applyStimulus(8'h08, 32'h0000_0000);
      applyStimulus(8'h18, 32'hFFFF_FFFF);
      readReg("unmapped", 8'h18, 32'h0);
      readReg("ctrl_after_unmapped", 8'h00, 32'h0000_000A);
      applyStimulus(8'h00, 32'h0000_0071);
      readReg("mme_clamp", 8'h00, 32'h0000_005B);

      $display("[TB] single MSI latency");
      applyStimulus(8'h0C, 32'h0000_4000);
      applyStimulus(8'h00, 32'h0000_0001);
      readReg("ctrl_en", 8'h00, 32'h0000_000B);
      pulseIrq(32'h1);
      checkOutput("lat_not_yet", {63'd0, msi_valid}, 64'd0);
      nextCycle();
      checkOutput("lat_valid", {63'd0, msi_valid}, 64'd1);
      checkOutput("lat_addr", msi_addr, 64'h0000_0000_FEE0_0000);
      checkOutput("lat_data", {48'd0, msi_data}, 64'h4000);
      nextCycle();
      checkOutput("lat_done", {63'd0, msi_valid}, 64'd0);

      $display("[TB] round robin");
      applyStimulus(8'h00, 32'h0000_0031);
      readReg("ctrl_mme3", 8'h00, 32'h0000_003B);
      logVec.delete(); logData.delete();
      pulseIrq(32'h0000_00A4);
      repeat (8) nextCycle();
      checkOutput("rr_count", 64'(logVec.size()), 64'd3);
      checkLog("rr_first", 0, 2, 16'h4002);
      checkLog("rr_second", 1, 5, 16'h4005);
      checkLog("rr_third", 2, 7, 16'h4007);
      logVec.delete(); logData.delete();
      pulseIrq(32'h0000_0009);
      repeat (6) nextCycle();
      checkOutput("rr_wrap_count", 64'(logVec.size()), 64'd2);
      checkLog("rr_wrap_first", 0, 0, 16'h4000);
      checkLog("rr_wrap_second", 1, 3, 16'h4003);

      $display("[TB] stall with DATA rewrite");
      msi_ready = 1'b0;
      pulseIrq(32'h0000_0002);
      nextCycle();
      for (int i = 0; i < 10; i++) begin
         if (i == 3) applyStimulus(8'h0C, 32'h0000_1234);
         else        nextCycle();
         checkOutput("stall_valid", {63'd0, msi_valid}, 64'd1);
         checkOutput("stall_data", {48'd0, msi_data}, 64'h4001);
         checkOutput("stall_addr", msi_addr, 64'h0000_0000_FEE0_0000);
      end
      msi_ready = 1'b1;
      nextCycle();
      checkOutput("stall_release", {63'd0, msi_valid}, 64'd0);
      logVec.delete(); logData.delete();
      pulseIrq(32'h0000_0008);
      repeat (3) nextCycle();
      checkLog("new_data_used", 0, 3, 16'h1233);
      applyStimulus(8'h0C, 32'h0000_4000);

`ifdef MSI_PER_VECTOR_MASK_EN
      $display("[TB] per-vector mask");
      applyStimulus(8'h10, 32'h0000_0001);
      logVec.delete(); logData.delete();
      pulseIrq(32'h1);
      repeat (3) nextCycle();
      checkOutput("masked_no_msi", {63'd0, msi_valid}, 64'd0);
      readReg("mask_read", 8'h10, 32'h1);
      readReg("pending_set", 8'h14, 32'h1);
      applyStimulus(8'h10, 32'h0);
      repeat (3) nextCycle();
      checkLog("unmasked_msi", 0, 0, 16'h4000);
      readReg("pending_clear", 8'h14, 32'h0);
`else
      $display("[TB] mask not implemented");
      applyStimulus(8'h10, 32'hFFFF_FFFF);
      readReg("mask_reads_zero", 8'h10, 32'h0);
      logVec.delete(); logData.delete();
      pulseIrq(32'h1);
      repeat (4) nextCycle();
      checkLog("unmasked_msi", 0, 0, 16'h4000);
      readReg("pending_reads_zero", 8'h14, 32'h0);
`endif

      $display("[TB] disabled coalescing");
      applyStimulus(8'h00, 32'h0000_0030);
      logVec.delete(); logData.delete();
      pulseIrq(32'h10);
      nextCycle();
      pulseIrq(32'h10);
      pulseIrq(32'h10);
      repeat (3) nextCycle();
      checkOutput("dis_enabled", {63'd0, msi_enabled}, 64'd0);
      checkOutput("dis_no_msi", 64'(logVec.size()), 64'd0);
`ifdef MSI_PER_VECTOR_MASK_EN
      readReg("dis_pending", 8'h14, 32'h10);
`endif
      applyStimulus(8'h00, 32'h0000_0031);
      repeat (6) nextCycle();
      checkOutput("coalesced_count", 64'(logVec.size()), 64'd1);
      checkLog("coalesced_msi", 0, 4, 16'h4004);

      $display("[TB] event on handshake cycle");
      logVec.delete(); logData.delete();
      msi_ready = 1'b0;
      pulseIrq(32'h4);
      nextCycle();
      irq_req   = 32'h4;
      msi_ready = 1'b1;
      nextCycle();
      irq_req = '0;
      repeat (4) nextCycle();
      checkOutput("kept_count", 64'(logVec.size()), 64'd2);
      checkLog("kept_first", 0, 2, 16'h4002);
      checkLog("kept_second", 1, 2, 16'h4002);

      $display("[TB] fold and reset mid-request");
      applyStimulus(8'h00, 32'h0000_0011);
      msi_ready = 1'b0;
      pulseIrq(32'h40);
      nextCycle();
      checkOutput("fold_valid", {63'd0, msi_valid}, 64'd1);
      checkOutput("fold_vector", {59'd0, msi_vector}, 64'd1);
      checkOutput("fold_data", {48'd0, msi_data}, 64'h4001);
      rst = 1'b1;
      #1;
      checkOutput("async_valid", {63'd0, msi_valid}, 64'd0);
      checkOutput("async_enabled", {63'd0, msi_enabled}, 64'd0);
      checkOutput("async_addr", msi_addr, 64'd0);
      checkOutput("async_data", {48'd0, msi_data}, 64'd0);
      readReg("rst2_ctrl", 8'h00, 32'h0000_000A);
      readReg("rst2_addr_lo", 8'h04, 32'h0);
      readReg("rst2_data", 8'h0C, 32'h0);
      rst = 1'b0;
      msi_ready = 1'b1;
      repeat (3) nextCycle();
      checkOutput("rst2_no_msi", {63'd0, msi_valid}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
